// File: rtl/result_queue_drain.sv
// result_queue_drain: pops num_words result words and writes them to consecutive addresses over Avalon-MM.
// Define RQD_CHECKSUM_EN to build the running checksum of accepted write data.
module result_queue_drain #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              rq_re,
    input  logic              rq_empty,
    input  logic [WIDTH-1:0]  rq_q,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [WIDTH-1:0]  avm_writedata,
    input  logic              avm_waitrequest,
    output logic [WIDTH-1:0]  checksum
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] fetch_left, rem_left;
    logic [WIDTH-1:0] fifo [2];
    logic [1:0] occ, occ_n;
    logic push_pos, in_flight, accept, out_free, pop, push, start_ok;
    assign start_ok = state == S_IDLE && start;
    assign accept   = avm_write && !avm_waitrequest;
    // The write register refills from the buffer head, or straight from the queue when the buffer is empty.
    assign out_free = !avm_write || accept;
    assign pop      = out_free && occ != 2'd0;
    assign push     = in_flight && !(out_free && occ == 2'd0);
    assign occ_n    = occ + {1'b0, push} - {1'b0, pop};
    assign push_pos = pop ? occ[1] : occ[0];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state == S_IDLE ? (start ? (num_words == '0 ? S_DONE : S_RUN) : S_IDLE) :
                  state == S_RUN  ? (accept && rem_left == CNT_W'(1) ? S_DONE : S_RUN) : S_IDLE;
    end
    always_comb begin
        busy  = state != S_IDLE;
        done  = state == S_DONE;
        rq_re = state == S_RUN && !rq_empty && fetch_left != '0 && (occ + {1'b0, in_flight}) < 2'd2;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_left    <= '0;
            rem_left      <= '0;
            in_flight     <= 1'b0;
            occ           <= 2'd0;
            fifo          <= '{default: '0};
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            in_flight <= rq_re;
            occ       <= occ_n;
            if (pop) fifo[0] <= fifo[1];
            if (push) fifo[push_pos] <= rq_q;
            if (out_free) begin
                avm_write <= pop || in_flight;
                if (pop || in_flight) avm_writedata <= pop ? fifo[0] : rq_q;
            end
            fetch_left  <= start_ok ? num_words : fetch_left - CNT_W'(rq_re);
            rem_left    <= start_ok ? num_words : rem_left - CNT_W'(accept);
            avm_address <= start_ok ? base_addr : avm_address + (accept ? ADDR_W'(WIDTH / 8) : '0);
        end
    end
`ifdef RQD_CHECKSUM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (accept) checksum <= checksum + avm_writedata;
    end
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_result_queue_drain.sv
// tb_result_queue_drain: randomized and directed stimulus against a queue-level scoreboard model.
`timescale 1ns/1ps
module tb_result_queue_drain;
    localparam int W  = 32;
    localparam int AW = 32;
    localparam int CW = 16;
    logic clk = 1'b0, resetn = 1'b1, start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_words = '0;
    logic busy, done, rq_re, avm_write;
    logic rq_empty = 1'b1, avm_waitrequest = 1'b0;
    logic [W-1:0] rq_q = '0, avm_writedata, checksum;
    logic [AW-1:0] avm_address;

    always #5 clk = ~clk;

    result_queue_drain #(.WIDTH(W), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .rq_re(rq_re), .rq_empty(rq_empty), .rq_q(rq_q),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .checksum(checksum)
    );

    int checks = 0, failures = 0, cyc_n = 0;
    logic [W-1:0] src_q[$], exp_q[$], acc_data[$];
    logic [AW-1:0] acc_addr[$];
    int acc_cyc[$];
    logic [AW-1:0] exp_addr = '0;
    logic [W-1:0] sum_m = '0, pend_word = '0;
    int reads_left = 0, writes_left = 0, re_cnt = 0, first_re = -1, done_cyc = -1;
    bit pend = 0, m_busy = 0, done_next = 0, prev_stall = 0, force_empty = 0, wr_stall = 0, go = 0;
    int empty_pct = 0, wait_pct = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_n);
        end
    endtask

    task automatic clr();
        acc_data.delete(); acc_addr.delete(); acc_cyc.delete();
        re_cnt = 0; first_re = -1; done_cyc = -1;
    endtask

    // Sampled mid-cycle: queue reads feed the expected write stream in pop order.
    task automatic monitor();
        bit done_exp, acc;
        done_exp = done_next;
        done_next = 0;
        chk("done", done, done_exp);
        chk("busy", busy, m_busy);
        chk("re_while_empty", rq_re & rq_empty, 0);
`ifdef RQD_CHECKSUM_EN
        chk("checksum", checksum, sum_m);
`else
        chk("checksum_off", checksum, 0);
`endif
        if (done) done_cyc = cyc_n;
        if (prev_stall) chk("held_write", avm_write, 1);
        pend = 0;
        if (rq_re) begin
            re_cnt++;
            if (first_re < 0) first_re = cyc_n;
            chk("over_read", reads_left > 0, 1);
            if (src_q.size() > 0) begin
                pend_word = src_q.pop_front();
                exp_q.push_back(pend_word);
                pend = 1;
            end
            reads_left--;
        end
        acc = avm_write && !avm_waitrequest;
        if (avm_write) begin
            chk("write_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("wr_data", avm_writedata, exp_q[0]);
                chk("wr_addr", avm_address, exp_addr);
            end
        end
        if (acc) begin
            acc_data.push_back(avm_writedata);
            acc_addr.push_back(avm_address);
            acc_cyc.push_back(cyc_n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_addr += AW'(4);
            sum_m += avm_writedata;
            writes_left--;
            if (writes_left == 0) done_next = 1;
        end
        prev_stall = avm_write && avm_waitrequest;
        if (start && !m_busy) begin
            m_busy = 1;
            reads_left = int'(num_words);
            writes_left = int'(num_words);
            exp_addr = base_addr;
            sum_m = '0;
            if (num_words == '0) done_next = 1;
        end
        if (done_exp) m_busy = 0;
    endtask

    task automatic step();
        @(negedge clk);
        start = go;
        rq_q = pend ? pend_word : W'($urandom);
        rq_empty = force_empty || src_q.size() == 0 || int'($urandom_range(99)) < empty_pct;
        avm_waitrequest = wr_stall || int'($urandom_range(99)) < wait_pct;
        #1;
        monitor();
        cyc_n++;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input int n, output int t0);
        base_addr = b;
        num_words = CW'(n);
        go = 1;
        t0 = cyc_n;
        step();
        go = 0;
    endtask

    task automatic finish_xfer();
        int n = 0;
        while (m_busy && n < 3000) begin
            step();
            n++;
        end
        chk("xfer_timeout", m_busy, 0);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rq_re"}, rq_re, 0);
        chk({tag, "_avm_write"}, avm_write, 0);
        chk({tag, "_avm_address"}, avm_address, 0);
        chk({tag, "_avm_writedata"}, avm_writedata, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, hits;
        logic [W-1:0] w[8];
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (2) step();

        // Basic 4-word drain with literal latency, data and address expectations.
        clr();
        src_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        do_start(32'h1000, 4, t0);
        finish_xfer();
        chk("lat_re", first_re, t0 + 1);
        chk("basic_count", acc_data.size(), 4);
        if (acc_data.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("basic_cyc", acc_cyc[i], t0 + 3 + i);
                chk("basic_data", acc_data[i], 32'h11 * (i + 1));
                chk("basic_addr", acc_addr[i], 32'h1000 + 4 * i);
            end
        chk("basic_done_cyc", done_cyc, t0 + 7);

        // Zero-length transfer.
        clr();
        src_q = '{32'h5, 32'h6};
        do_start(32'h2000, 0, t0);
        finish_xfer();
        chk("zero_done_cyc", done_cyc, t0 + 1);
        chk("zero_reads", re_cnt, 0);
        chk("zero_writes", acc_data.size(), 0);
        src_q.delete();

        // Waitrequest held for 5 cycles on word 2.
        clr();
        for (int i = 0; i < 6; i++) src_q.push_back(W'($urandom));
        do_start(32'h3000, 6, t0);
        for (int i = 0; i < 50 && acc_data.size() < 1; i++) step();
        wr_stall = 1;
        repeat (5) step();
        chk("stall_re_stopped", rq_re, 0);
        chk("stall_write_held", avm_write, 1);
        wr_stall = 0;
        finish_xfer();
        chk("stall_count", acc_data.size(), 6);

        // Queue empty for 10 cycles in the middle of 8 words.
        clr();
        for (int i = 0; i < 8; i++) begin
            w[i] = W'($urandom);
            src_q.push_back(w[i]);
        end
        do_start(32'h4000, 8, t0);
        for (int i = 0; i < 50 && acc_data.size() < 3; i++) step();
        force_empty = 1;
        hits = re_cnt;
        repeat (10) step();
        chk("empty_no_reads", re_cnt - hits, 0);
        force_empty = 0;
        finish_xfer();
        chk("empty_count", acc_data.size(), 8);
        if (acc_data.size() == 8)
            for (int i = 0; i < 8; i++) chk("empty_order", acc_data[i], w[i]);

        // Address wrap.
        clr();
        src_q = '{32'hA, 32'hB};
        do_start(32'hFFFF_FFFC, 2, t0);
        finish_xfer();
        chk("wrap_count", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            chk("wrap_addr0", acc_addr[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", acc_addr[1], 32'h0);
        end

        // Reset with a read in flight, then a clean transfer.
        clr();
        for (int i = 0; i < 8; i++) src_q.push_back(W'($urandom));
        do_start(32'h5000, 8, t0);
        for (int i = 0; i < 20 && !pend; i++) step();
        chk("rst_read_in_flight", pend, 1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cyc_n++;
        src_q.delete(); exp_q.delete();
        pend = 0; m_busy = 0; done_next = 0; prev_stall = 0;
        reads_left = 0; writes_left = 0; sum_m = '0;
        repeat (2) step();
        resetn = 1'b1;
        step();
        clr();
        for (int i = 0; i < 3; i++) src_q.push_back(W'($urandom));
        do_start(32'h6000, 3, t0);
        finish_xfer();
        chk("post_rst_count", acc_data.size(), 3);

`ifdef RQD_CHECKSUM_EN
        clr();
        src_q = '{32'h1, 32'h2, 32'hFFFF_FFFF};
        do_start(32'h7000, 3, t0);
        finish_xfer();
        chk("checksum_lit", checksum, 32'h2);
`endif

        // Randomized transfers with queue and slave stalls.
        empty_pct = 25;
        wait_pct = 30;
        for (int k = 0; k < 25; k++) begin
            int n;
            n = int'($urandom_range(12));
            clr();
            for (int i = 0; i < n; i++) src_q.push_back(W'($urandom));
            do_start(AW'($urandom), n, t0);
            finish_xfer();
            chk("rand_count", acc_data.size(), n);
            src_q.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
